// File: rtl/node_sequencer.sv
// Control stage for the node array: clears the accumulators, steps the shared input index,
// captures every node activation, then offers the captured vector over valid/ready.
module node_sequencer #(
  parameter int IMAGE_SIZE = 64,
  parameter int NUM_NODES  = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    go,
  input  logic                    abort,
  output logic [6:0]              cnt_val,
  output logic                    acc_clr,
  output logic                    acc_hold,
  input  logic [16*NUM_NODES-1:0] node_out,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*NUM_NODES-1:0] result
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, CAPTURE, DONE} state_t;

  localparam logic [6:0] LAST_CNT = 7'(IMAGE_SIZE - 1);

  state_t      state_reg, state_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        capture_en;
  logic [15:0] result_reg [NUM_NODES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 7'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture_en = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = 7'd0;
        if (go) state_next = CLEAR;
      end
      CLEAR: begin
        cnt_next   = 7'd0;
        state_next = ACCUM;
      end
      ACCUM: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = 7'd0;
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 7'd0;
      end
    endcase
    // Abort overrides everything outside IDLE, including a pending capture.
    if (state_reg != IDLE && abort) begin
      state_next = IDLE;
      cnt_next   = 7'd0;
      capture_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_NODES; i++) result_reg[i] <= 16'd0;
    end else if (capture_en) begin
      for (int i = 0; i < NUM_NODES; i++) result_reg[i] <= node_out[16*i +: 16];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_result
      assign result[16*gi +: 16] = result_reg[gi];
    end
  endgenerate

  assign cnt_val   = cnt_reg;
  assign acc_clr   = (state_reg == CLEAR);
  assign acc_hold  = (state_reg != ACCUM);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_node_sequencer.sv
// Bench for node_sequencer: a small instance checked cycle by cycle against a pass-timeline
// model plus a result scoreboard, and a default-size instance for latency and counter range.
module tb_node_sequencer;
  localparam int N  = 4;
  localparam int NN = 2;
  localparam int W  = 16 * NN;
  localparam int NB = 8;
  localparam int WB = 16 * NB;
  localparam logic [W+10:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b0, 7'd0, {W{1'b0}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst = 1'b0, go = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  node_out = '0;
  logic [6:0]    cnt_val;
  logic          acc_clr, acc_hold, busy, out_valid;
  logic [W-1:0]  result;

  logic          n_rst_b = 1'b0, go_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b0;
  logic [WB-1:0] node_out_b = '0;
  logic [6:0]    cnt_val_b;
  logic          acc_clr_b, acc_hold_b, busy_b, out_valid_b;
  logic [WB-1:0] result_b;

  node_sequencer #(.IMAGE_SIZE(N), .NUM_NODES(NN)) dut (
    .clk(clk), .n_rst(n_rst), .go(go), .abort(abort), .cnt_val(cnt_val),
    .acc_clr(acc_clr), .acc_hold(acc_hold), .node_out(node_out), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result));

  node_sequencer dut_b (
    .clk(clk), .n_rst(n_rst_b), .go(go_b), .abort(abort_b), .cnt_val(cnt_val_b),
    .acc_clr(acc_clr_b), .acc_hold(acc_hold_b), .node_out(node_out_b), .busy(busy_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .result(result_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within a pass (0 = idle, 1 = clear, 2..N+1 = accumulate,
  // N+2 = capture, N+3 = done) plus the last captured vector.
  int           m_t = 0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] exp_q [$];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_t = 0;
      m_result = '0;
      exp_q.delete();
    end else if (m_t == 0) begin
      if (go) m_t = 1;
    end else if (abort) begin
      m_t = 0;
    end else if (m_t == N + 2) begin
      m_result = node_out;
      exp_q.push_back(node_out);
      m_t = N + 3;
    end else if (m_t >= N + 3) begin
      if (out_ready) m_t = 0;
    end else begin
      m_t++;
    end
  end

  function automatic logic [W+10:0] exp_vec(input int t, input logic [W-1:0] r);
    logic       acc;
    logic [6:0] c;
    acc = (t >= 2) && (t <= N + 1);
    c = acc ? 7'(t - 2) : 7'd0;
    return {(t != 0), (t == 1), !acc, (t >= N + 3), c, r};
  endfunction

  logic [W+10:0] dut_vec;
  assign dut_vec = {busy, acc_clr, acc_hold, out_valid, cnt_val, result};

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) check("ctrl", dut_vec, exp_vec(m_t, m_result));
  end

  // Scoreboard monitor: each new result offer must match the oldest predicted capture.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (chk_en && out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected t=%0t actual=%0h required=none", $time, result);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", result, e);
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int max_cnt;
    logic [WB-1:0] held_b;

    // Reset state
    #2 check("reset_vals", dut_vec, RST_VEC);
    repeat (2) @(negedge clk);
    check("reset_held", dut_vec, RST_VEC);
    n_rst = 1'b1;
    n_rst_b = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Normal pass with 10 cycles of backpressure
    node_out = 32'h1234_ABCD;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (6) @(negedge clk);
    check("valid_cycle7", {out_valid, result}, {1'b1, 32'h1234_ABCD});
    for (int i = 0; i < 10; i++) begin
      node_out = $urandom;
      @(negedge clk);
    end
    check("bp_stable", {out_valid, result}, {1'b1, 32'h1234_ABCD});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handshake", {out_valid, busy}, 2'b00);

    // Abort at cnt_val = 2
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 20 && cnt_val != 7'd2; i++) @(negedge clk);
    check("abort_wait", cnt_val, 7'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort", {busy, cnt_val, acc_hold, result}, {1'b0, 7'd0, 1'b1, 32'h1234_ABCD});

    // go held high with ready high: back-to-back passes
    node_out = $urandom;
    go = 1'b1;
    out_ready = 1'b1;
    repeat (3 * (N + 5)) @(negedge clk);
    go = 1'b0;
    out_ready = 1'b0;
    repeat (N + 6) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      go = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      out_ready = $urandom_range(0, 1);
      node_out = $urandom;
      @(negedge clk);
    end
    go = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (N + 6) @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset mid-accumulate, then a clean pass
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 20 && cnt_val != 7'd1; i++) @(negedge clk);
    check("rst_wait", cnt_val, 7'd1);
    #2 n_rst = 1'b0;
    #1 check("rst_async", dut_vec, RST_VEC);
    repeat (2) @(negedge clk);
    check("rst_hold", dut_vec, RST_VEC);
    n_rst = 1'b1;
    @(negedge clk);
    node_out = 32'hCAFE_0042;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    out_ready = 1'b1;
    repeat (N + 3) @(negedge clk);
    out_ready = 1'b0;
    check("post_rst_result", result, 32'hCAFE_0042);
    chk_en = 1'b0;

    // Default-size instance: latency and counter range
    held_b = {$urandom, $urandom, $urandom, $urandom};
    node_out_b = held_b;
    go_b = 1'b1;
    lat = 0;
    max_cnt = 0;
    for (int i = 0; i < 200 && !out_valid_b; i++) begin
      @(negedge clk);
      go_b = 1'b0;
      lat++;
      if (int'(cnt_val_b) > max_cnt) max_cnt = int'(cnt_val_b);
    end
    check("latency_67", lat, 67);
    check("cnt_max_63", max_cnt, 63);
    check("result_b", result_b, held_b);
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
    check("busy_b_drop", {busy_b, out_valid_b}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
